// File: rtl/sprite_mover.sv
// sprite_mover: synchronizes and debounces four active-low pushbuttons and
// steps a clamped sprite position once per frame on the vsync falling edge.
module sprite_mover #(
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned SCREEN_H        = 480,
  parameter int unsigned SPRITE_W        = 32,
  parameter int unsigned SPRITE_H        = 32,
  parameter int unsigned STEP            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned X_INIT          = 304,
  parameter int unsigned Y_INIT          = 224
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_up_n,
  input  logic       move_down_n,
  input  logic       move_left_n,
  input  logic       move_right_n,
  input  logic       vsync_n,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       pos_update,
  output logic [3:0] dir_held
);

  localparam int unsigned CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned X_MAX = SCREEN_W - SPRITE_W;
  localparam int unsigned Y_MAX = SCREEN_H - SPRITE_H;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0]   STEP11   = 11'(STEP);
  localparam logic [10:0]   XMAX11   = 11'(X_MAX);
  localparam logic [10:0]   YMAX11   = 11'(Y_MAX);
  localparam logic [9:0]    STEP10   = 10'(STEP);

  // Bit order {vsync, up, down, left, right}; buttons line up with dir_held.
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [3:0]    pressed;
  logic [CW-1:0] cnt [4];
  logic          vs_prev;
  logic          tick;
  logic [10:0]   x_sum;
  logic [10:0]   y_sum;
  logic [9:0]    x_next;
  logic [9:0]    y_next;

  assign pressed = ~sync2[3:0];

  // Two-flop synchronizers, idle-high so reset never looks like a press or edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {vsync_n, move_up_n, move_down_n, move_left_n, move_right_n};
      sync2 <= sync1;
    end
  end

  // Per-button debounce: level flips only after DEBOUNCE_CYCLES disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      dir_held <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pressed[i] == dir_held[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]      <= '0;
          dir_held[i] <= ~dir_held[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Registered falling-edge detect on synchronized vsync gives one tick per frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      vs_prev <= 1'b1;
      tick    <= 1'b0;
    end else begin
      vs_prev <= sync2[4];
      tick    <= vs_prev & ~sync2[4];
    end
  end

  // Candidate position: opposing buttons cancel; sums are 11 bits so clamping never sees a wrap.
  always_comb begin
    x_sum  = {1'b0, sprite_x} + STEP11;
    y_sum  = {1'b0, sprite_y} + STEP11;
    x_next = sprite_x;
    y_next = sprite_y;
    if (dir_held[1] && !dir_held[0]) begin
      x_next = (sprite_x >= STEP10) ? (sprite_x - STEP10) : '0;
    end else if (dir_held[0] && !dir_held[1]) begin
      x_next = (x_sum > XMAX11) ? XMAX11[9:0] : x_sum[9:0];
    end
    if (dir_held[3] && !dir_held[2]) begin
      y_next = (sprite_y >= STEP10) ? (sprite_y - STEP10) : '0;
    end else if (dir_held[2] && !dir_held[3]) begin
      y_next = (y_sum > YMAX11) ? YMAX11[9:0] : y_sum[9:0];
    end
  end

  // Position register, updated only on the frame tick; pulse flags a real change.
  always_ff @(posedge clock) begin
    if (reset) begin
      sprite_x   <= 10'(X_INIT);
      sprite_y   <= 10'(Y_INIT);
      pos_update <= 1'b0;
    end else if (tick) begin
      sprite_x   <= x_next;
      sprite_y   <= y_next;
      pos_update <= (x_next != sprite_x) || (y_next != sprite_y);
    end else begin
      pos_update <= 1'b0;
    end
  end

endmodule
